// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and butterfly address arithmetic for the
// radix-2 DIT FFT stage sequencer.
package fft_pkg;

  localparam int LOG2N     = 5;
  localparam int N         = 1 << LOG2N;
  localparam int RD_LAT    = 1;
  localparam int BF_LAT    = 3;
  localparam int DLY_DEPTH = RD_LAT + BF_LAT;
  localparam int A_TAP     = BF_LAT - 1;

  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [LOG2N-1:0] stage_t;
  typedef logic [LOG2N-2:0] bf_idx_t;
  typedef logic [LOG2N-2:0] tw_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    addr_t a;
    addr_t b;
    tw_t   tw;
  } bf_addr_t;

  // Operand pair and twiddle index for butterfly j of stage s.
  function automatic bf_addr_t bf_addr(input bf_idx_t j, input stage_t s);
    addr_t    jx;
    addr_t    mask;
    bf_addr_t r;
    jx   = addr_t'(j);
    mask = addr_t'((1 << s) - 1);
    r.a  = ((jx >> s) << (s + 1)) | (jx & mask);
    r.b  = r.a + addr_t'(1 << s);
    r.tw = tw_t'((jx & mask) << (LOG2N - 1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Control/address bundle between the FFT sequencer and its host, sample RAM
// and butterfly unit. FFT_CTRL_STALL_EN adds the issue stall input.
interface fft_stage_ctrl_if;
  import fft_pkg::*;

  logic    start;
`ifdef FFT_CTRL_STALL_EN
  logic    stall;
`endif
  logic    busy;
  logic    done;
  stage_t  stage;
  logic    rd_en_b;
  addr_t   rd_addr_b;
  tw_t     twiddle_num;
  logic    rd_en_a;
  addr_t   rd_addr_a;
  logic    wr_en;
  addr_t   wr_addr_a;
  addr_t   wr_addr_b;

  modport ctrl (
`ifdef FFT_CTRL_STALL_EN
    input  stall,
`endif
    input  start,
    output busy, done, stage,
    output rd_en_b, rd_addr_b, twiddle_num,
    output rd_en_a, rd_addr_a,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport host (
`ifdef FFT_CTRL_STALL_EN
    output stall,
`endif
    output start,
    input  busy, done, stage,
    input  rd_en_b, rd_addr_b, twiddle_num,
    input  rd_en_a, rd_addr_a,
    input  wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_bf_delay.sv
// Free-running {valid, a, b} shift line that mirrors the butterfly pipeline;
// taps give the A-operand read and the write-back, addresses zeroed when idle.
module fft_bf_delay #(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int A_TAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [AW-1:0] in_a_i,
  input  logic [AW-1:0] in_b_i,
  output logic          rd_valid_o,
  output logic [AW-1:0] rd_a_o,
  output logic          wr_valid_o,
  output logic [AW-1:0] wr_a_o,
  output logic [AW-1:0] wr_b_o,
  output logic          pending_o
);

  logic [DEPTH:1] valid_q;
  logic [AW-1:0]  a_q [1:DEPTH];
  logic [AW-1:0]  b_q [1:DEPTH];

  for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_stage
    if (gi == 1) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          a_q[gi]     <= '0;
          b_q[gi]     <= '0;
        end else begin
          valid_q[gi] <= in_valid_i;
          a_q[gi]     <= in_a_i;
          b_q[gi]     <= in_b_i;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          a_q[gi]     <= '0;
          b_q[gi]     <= '0;
        end else begin
          valid_q[gi] <= valid_q[gi-1];
          a_q[gi]     <= a_q[gi-1];
          b_q[gi]     <= b_q[gi-1];
        end
      end
    end
  end

  assign rd_valid_o = valid_q[A_TAP];
  assign rd_a_o     = valid_q[A_TAP] ? a_q[A_TAP] : '0;
  assign wr_valid_o = valid_q[DEPTH];
  assign wr_a_o     = valid_q[DEPTH] ? a_q[DEPTH] : '0;
  assign wr_b_o     = valid_q[DEPTH] ? b_q[DEPTH] : '0;

  // The last slot is retiring this cycle, so it does not hold the line busy.
  assign pending_o  = in_valid_i | (|valid_q[DEPTH-1:1]);

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT stage/butterfly sequencer.
// Optional FFT_CTRL_STALL_EN adds a stall input that pauses issue in ISSUE.
module fft_stage_ctrl
  import fft_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fft_stage_ctrl_if.ctrl bus
);

  state_e   state_q, state_d;
  bf_idx_t  j_q, j_d;
  stage_t   s_q, s_d;
  logic     stall_w;
  logic     issue_w;
  logic     pending_w;
  bf_addr_t bf_w;

`ifdef FFT_CTRL_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  assign issue_w = (state_q == ST_ISSUE) && !stall_w;
  assign bf_w    = bf_addr(j_q, s_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          j_d     = '0;
          s_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (issue_w) begin
          if (j_q == bf_idx_t'(N/2 - 1)) begin
            state_d = ST_DRAIN;
            j_d     = '0;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!pending_w) begin
          if (s_q == stage_t'(LOG2N - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            s_d     = s_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    bus.done        = (state_q == ST_DONE);
    bus.stage       = s_q;
    bus.rd_en_b     = issue_w;
    bus.rd_addr_b   = issue_w ? bf_w.b  : '0;
    bus.twiddle_num = issue_w ? bf_w.tw : '0;
  end

  fft_bf_delay #(
    .AW    (LOG2N),
    .DEPTH (DLY_DEPTH),
    .A_TAP (A_TAP)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (issue_w),
    .in_a_i     (bf_w.a),
    .in_b_i     (bf_w.b),
    .rd_valid_o (bus.rd_en_a),
    .rd_a_o     (bus.rd_addr_a),
    .wr_valid_o (bus.wr_en),
    .wr_a_o     (bus.wr_addr_a),
    .wr_b_o     (bus.wr_addr_b),
    .pending_o  (pending_w)
  );

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: cycle-exact address/strobe timeline,
// hand-computed spot vectors, busy-start rejection and mid-transform reset.
module tb_fft_stage_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fft_stage_ctrl_if bus_if ();

  fft_stage_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Butterfly issued in transform cycle c (cycle 1 = first after start accept).
  function automatic bit iss_info(input int c, output int k, output int j);
    k = 0;
    j = 0;
    if (c < 1 || c > 100) return 1'b0;
    k = (c - 1) / 20;
    j = (c - 1) % 20;
    return (j < 16);
  endfunction

  task automatic check_cycle(input int t);
    int k, j, a, b, tw;
    bit v;
    v  = iss_info(t, k, j);
    a  = j + ((j >> k) << k);
    b  = a + (1 << k);
    tw = (j % (1 << k)) * (16 >> k);
    chk($sformatf("rd_en_b@%0d", t), 32'(bus_if.rd_en_b), 32'(v));
    chk($sformatf("rd_addr_b@%0d", t), 32'(bus_if.rd_addr_b), v ? b : 0);
    chk($sformatf("twiddle@%0d", t), 32'(bus_if.twiddle_num), v ? tw : 0);
    v  = iss_info(t - 2, k, j);
    a  = j + ((j >> k) << k);
    chk($sformatf("rd_en_a@%0d", t), 32'(bus_if.rd_en_a), 32'(v));
    chk($sformatf("rd_addr_a@%0d", t), 32'(bus_if.rd_addr_a), v ? a : 0);
    v  = iss_info(t - 4, k, j);
    a  = j + ((j >> k) << k);
    b  = a + (1 << k);
    chk($sformatf("wr_en@%0d", t), 32'(bus_if.wr_en), 32'(v));
    chk($sformatf("wr_addr_a@%0d", t), 32'(bus_if.wr_addr_a), v ? a : 0);
    chk($sformatf("wr_addr_b@%0d", t), 32'(bus_if.wr_addr_b), v ? b : 0);
    chk($sformatf("busy@%0d", t), 32'(bus_if.busy), 32'(t <= 100));
    chk($sformatf("done@%0d", t), 32'(bus_if.done), 32'(t == 101));
    if (t <= 101) chk($sformatf("stage@%0d", t), 32'(bus_if.stage), (t <= 100) ? (t - 1) / 20 : 4);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus_if.busy), 0);
    chk({tag, "_done"}, 32'(bus_if.done), 0);
    chk({tag, "_stage"}, 32'(bus_if.stage), 0);
    chk({tag, "_rd_en_b"}, 32'(bus_if.rd_en_b), 0);
    chk({tag, "_rd_addr_b"}, 32'(bus_if.rd_addr_b), 0);
    chk({tag, "_twiddle"}, 32'(bus_if.twiddle_num), 0);
    chk({tag, "_rd_en_a"}, 32'(bus_if.rd_en_a), 0);
    chk({tag, "_rd_addr_a"}, 32'(bus_if.rd_addr_a), 0);
    chk({tag, "_wr_en"}, 32'(bus_if.wr_en), 0);
    chk({tag, "_wr_addr_a"}, 32'(bus_if.wr_addr_a), 0);
    chk({tag, "_wr_addr_b"}, 32'(bus_if.wr_addr_b), 0);
  endtask

  // Starts a transform and observes cycles 1..tmax at each falling edge.
  task automatic run(input int tmax, input bit model_on, input int stall_at,
                     output int done_t, output int done_cnt, output int wr_cnt,
                     output int iss_cnt);
    bit iss [0:255];
    done_t   = 0;
    done_cnt = 0;
    wr_cnt   = 0;
    iss_cnt  = 0;
    for (int i = 0; i < 256; i++) iss[i] = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int t = 1; t <= tmax; t++) begin
      if (t > 1) @(negedge clk);
      if (model_on) check_cycle(t);
      iss[t] = bus_if.rd_en_b;
      if (bus_if.rd_en_b) iss_cnt++;
      if (bus_if.wr_en) begin
        wr_cnt++;
        chk($sformatf("wr_lag4@%0d", t), (t >= 5) ? 32'(iss[t-4]) : 32'd0, 1);
      end
      if (bus_if.done) begin
        done_cnt++;
        done_t = t;
      end
      if (model_on) begin
        if (t == 4)  begin chk("s0j3_rd_b", 32'(bus_if.rd_addr_b), 7); chk("s0j3_tw", 32'(bus_if.twiddle_num), 0); end
        if (t == 6)  chk("s0j3_rd_a", 32'(bus_if.rd_addr_a), 6);
        if (t == 8)  begin chk("s0j3_wr_a", 32'(bus_if.wr_addr_a), 6); chk("s0j3_wr_b", 32'(bus_if.wr_addr_b), 7); end
        if (t == 47) begin chk("s2j6_rd_b", 32'(bus_if.rd_addr_b), 14); chk("s2j6_tw", 32'(bus_if.twiddle_num), 8); end
        if (t == 49) chk("s2j6_rd_a", 32'(bus_if.rd_addr_a), 10);
        if (t == 86) begin chk("s4j5_rd_b", 32'(bus_if.rd_addr_b), 21); chk("s4j5_tw", 32'(bus_if.twiddle_num), 5); end
        if (t == 88) chk("s4j5_rd_a", 32'(bus_if.rd_addr_a), 5);
      end
      bus_if.start = model_on && (t == 30);
`ifdef FFT_CTRL_STALL_EN
      bus_if.stall = (stall_at > 0) && (t >= stall_at - 1) && (t < stall_at + 2);
`else
      if (stall_at > 0) bus_if.start = bus_if.start;
`endif
    end
  endtask

  initial begin
    int done_t, done_cnt, wr_cnt, iss_cnt;
    bus_if.start = 1'b0;
`ifdef FFT_CTRL_STALL_EN
    bus_if.stall = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run(110, 1'b1, 0, done_t, done_cnt, wr_cnt, iss_cnt);
    chk("run1_done_cycle", done_t, 101);
    chk("run1_done_count", done_cnt, 1);
    chk("run1_wr_count", wr_cnt, 80);
    $display("transaction run1 done_cycle=%0d writes=%0d", done_t, wr_cnt);

    run(50, 1'b1, 0, done_t, done_cnt, wr_cnt, iss_cnt);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_wr_en@%0d", i), 32'(bus_if.wr_en), 0);
      chk($sformatf("postrst_busy@%0d", i), 32'(bus_if.busy), 0);
    end
    $display("transaction midreset checked");

    run(110, 1'b1, 0, done_t, done_cnt, wr_cnt, iss_cnt);
    chk("run3_done_cycle", done_t, 101);
    chk("run3_wr_count", wr_cnt, 80);
    $display("transaction run3 done_cycle=%0d writes=%0d", done_t, wr_cnt);

`ifdef FFT_CTRL_STALL_EN
    run(110, 1'b0, 25, done_t, done_cnt, wr_cnt, iss_cnt);
    chk("stall_done_cycle", done_t, 104);
    chk("stall_wr_count", wr_cnt, 80);
    chk("stall_iss_count", iss_cnt, 80);
    $display("transaction stall done_cycle=%0d writes=%0d", done_t, wr_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

In-place radix-2 DIT FFT sequencer that drives the shared butterfly datapath and its twiddle LUT. It walks all stages and butterflies of an N-point transform held in a dual-port sample RAM. Per butterfly, it issues operand read addresses and the twiddle index with the skew the butterfly pipeline requires, then issues the write-back addresses when results emerge. It sits between the top-level FFT control (start/done) and the sample RAM plus butterfly unit. Input samples are already bit-reversed by the loader.

## Interface
Parameters:
- LOG2N, 5: log2 of transform size. N = 32, 16 butterflies per stage, 5 stages.
- RD_LAT, 1: sample RAM read latency in cycles. Equals the twiddle LUT latency.
- BF_LAT, 3: butterfly latency from B/twiddle input edge to registered outputs.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a transform
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the final write-back
- stage  out  LOG2N  current stage index, 0..LOG2N-1
- rd_en_b  out  1  read strobe, port B operand
- rd_addr_b  out  LOG2N  B operand address
- twiddle_num  out  LOG2N-1  twiddle index, issued with rd_addr_b
- rd_en_a  out  1  read strobe, port A operand
- rd_addr_a  out  LOG2N  A operand address
- wr_en  out  1  write-back strobe for both results
- wr_addr_a  out  LOG2N  destination address for the butterfly A output
- wr_addr_b  out  LOG2N  destination address for the butterfly B output

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on start. Clears stage s and butterfly counter j.
- ISSUE: issues one butterfly per cycle, j = 0..N/2-1.
  - a = ((j >> s) << (s+1)) | (j & (2^s - 1))
  - b = a + 2^s
  - twiddle_num = (j & (2^s - 1)) << (LOG2N-1-s)
  - After j = N/2-1, go to DRAIN.
- DRAIN: wait until the internal delay line holds no valid entries. Then either increment s and return to ISSUE with j = 0, or, if s = LOG2N-1, go to DONE.
- DONE: pulse done for one cycle, deassert busy, go to IDLE.
- Delay line: a shift register of depth RD_LAT+BF_LAT carrying {valid, a, b}. It feeds the A-read tap and the write-back tap. It always shifts; the butterfly has no enable, so the controller never stalls it.
- start while busy is ignored.
- Address arithmetic is unsigned. All addresses are inside 0..N-1, so no wrap occurs.

## Timing
- Reset: every output is 0, state is IDLE, counters are 0, the delay line is cleared. Reset mid-transform abandons in-flight writes; wr_en is 0 from the next cycle.
- Butterfly issued in cycle c (rd_en_b=1, rd_addr_b, twiddle_num valid):
  - rd_en_a/rd_addr_a in cycle c+BF_LAT-1 (c+2). The butterfly samples A two edges after B.
  - wr_en/wr_addr_a/wr_addr_b in cycle c+RD_LAT+BF_LAT (c+4).
- Default per-stage timing: ISSUE 16 cycles, then DRAIN 4 cycles. The next stage's first read comes strictly after the previous stage's last write, so there is no RAW hazard.
- Full transform: start accepted in cycle 0, first issue in cycle 1, last write-back in cycle 100, done in cycle 101.
- rd_en_a and wr_en may overlap rd_en_b of later butterflies. These use independent RAM ports.

## Configuration
- FFT_CTRL_STALL_EN defined:
  - Adds input stall (1 bit).
  - In ISSUE, stall=1 suppresses issue that cycle: rd_en_b=0 and j holds.
  - The delay line keeps shifting, so in-flight A reads and writes complete on schedule.
  - DRAIN and DONE ignore stall.
- FFT_CTRL_STALL_EN undefined: no stall port; issue is unconditional every ISSUE cycle.

## Structure
- fft_pkg holds LOG2N, N, RD_LAT, BF_LAT, the state encoding, and a function for the a/b/twiddle computation.
- One sub-module, fft_bf_delay, implements the parameterised valid/address shift line with taps at BF_LAT-1 and RD_LAT+BF_LAT.

## Test plan
- Reset then single start: done asserts exactly in cycle 101, busy is high for cycles 1..100, and there are 80 wr_en pulses total.
- Stage 0, j=3: rd_addr_b=7 with twiddle_num=0; rd_addr_a=6 two cycles later; wr_addr_a=6 and wr_addr_b=7 four cycles after issue.
- Stage 4, j=5: rd_addr_b=21, twiddle_num=5, rd_addr_a=5. Stage 2, j=6: a=10, b=14, twiddle_num=8.
- start pulsed while busy → ignored, done count stays 1. rst in cycle 50 → all outputs 0 next cycle, no wr_en afterward, and a new start runs cleanly.
- With FFT_CTRL_STALL_EN, stall=1 for 3 cycles mid-stage 1 → 3 fewer issue cycles during the stall. Every issued butterfly's write still lands 4 cycles after its issue, and done is delayed by exactly 3 cycles.
- Scoreboard: a golden in-place FFT model is fed by the controller's address streams through the real butterfly unit. Outputs match within 1 LSB per stage for impulse and DC inputs.
